multicycle_core: RTL

Parametrised four-step multicycle processor core: fetches one instruction word per handshake, decodes it, executes it over 2 or 4 cycles against an internal register bank, and retires it with a one-cycle done pulse. It generalises the fixed 16-bit, 8-register processor to configurable data width and register count. It adds a ready/valid instruction fetch handshake and a dedicated output port with strobe. It sits between an instruction source (ROM sequencer or testbench) and downstream logic consuming `dout`.

---
 rtl/multicycle_core.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/multicycle_core.sv
// Four-step multicycle core: FETCH/DECODE/EXEC/WRITE over a register bank.
// Define MULTICYCLE_CORE_SLT_EN to enable signed SLT; otherwise opcode 6 is a NOP.
module multicycle_core #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [DATA_W-1:0] iin,
  input  logic              iin_valid,
  output logic              iin_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              done
);

  localparam int NREG  = 2**REG_AW;
  localparam int IMM_W = DATA_W - 3 - 2*REG_AW;

  typedef enum logic [1:0] {
    FETCH, DECODE, EXEC, WRITE
  } state_t;

  typedef enum logic [2:0] {
    OP_MV, OP_MVI, OP_ADD, OP_SUB,
    OP_AND, OP_OR, OP_SLT, OP_OUT
  } op_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] ir, a, g;
  logic [DATA_W-1:0] rf [NREG];

  op_t               op;
  logic [REG_AW-1:0] rx, ry;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] sext, rb, alu;
  logic              short_op, accept, alu_wr;

  logic              ld_ir, ld_a, ld_g;
  logic              rf_we, out_we, retire;
  logic [DATA_W-1:0] rf_wd;

  assign op   = op_t'(ir[DATA_W-1 -: 3]);
  assign rx   = ir[DATA_W-4 -: REG_AW];
  assign ry   = ir[DATA_W-4-REG_AW -: REG_AW];
  assign imm  = ir[IMM_W-1:0];
  assign sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign rb   = rf[ry];

  assign short_op = (op == OP_MV) || (op == OP_MVI)
                 || (op == OP_OUT);

  assign iin_ready = (state == FETCH) && resetn;
  assign accept    = iin_valid && iin_ready;

`ifdef MULTICYCLE_CORE_SLT_EN
  assign alu_wr = 1'b1;
`else
  // Opcode 6 still walks the long path but never writes back
  assign alu_wr = (op != OP_SLT);
`endif

  always_comb begin
    alu = '0;
    unique case (op)
      OP_ADD:  alu = a + rb;
      OP_SUB:  alu = a - rb;
      OP_AND:  alu = a & rb;
      OP_OR:   alu = a | rb;
`ifdef MULTICYCLE_CORE_SLT_EN
      OP_SLT:  alu = {{(DATA_W-1){1'b0}},
                      ($signed(a) < $signed(rb))};
`endif
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= FETCH;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FETCH:   if (accept) state_nx = DECODE;
      DECODE:  state_nx = short_op ? FETCH : EXEC;
      EXEC:    state_nx = WRITE;
      WRITE:   state_nx = FETCH;
      default: state_nx = FETCH;
    endcase
  end

  always_comb begin
    ld_ir  = 1'b0;
    ld_a   = 1'b0;
    ld_g   = 1'b0;
    rf_we  = 1'b0;
    rf_wd  = g;
    out_we = 1'b0;
    retire = 1'b0;
    unique case (1'b1)
      (state == FETCH): ld_ir = accept;
      (state == DECODE): begin
        retire = short_op;
        ld_a   = !short_op;
        rf_we  = (op == OP_MV) || (op == OP_MVI);
        rf_wd  = (op == OP_MVI) ? sext : rb;
        out_we = (op == OP_OUT);
      end
      (state == EXEC): ld_g = 1'b1;
      (state == WRITE): begin
        retire = 1'b1;
        rf_we  = alu_wr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ir         <= '0;
      a          <= '0;
      g          <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (ld_ir)  ir <= iin;
      if (ld_a)   a  <= rf[rx];
      if (ld_g)   g  <= alu;
      if (rf_we)  rf[rx] <= rf_wd;
      if (out_we) dout <= rf[rx];
      done       <= retire;
      dout_valid <= out_we;
    end
  end

endmodule
